// File: rtl/orpsoc_sim_pkg.sv
// orpsoc_sim_pkg: shared constants and types for the simulation supervisor.
//   NOP_*_DEF   - default l.nop instruction words for exit / report / putc
//   sim_state_e - supervisor FSM state encoding
package orpsoc_sim_pkg;

  localparam logic [31:0] NOP_EXIT_DEF   = 32'h15000001;
  localparam logic [31:0] NOP_REPORT_DEF = 32'h15000002;
  localparam logic [31:0] NOP_PUTC_DEF   = 32'h15000004;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2,
    StDone    = 2'd3
  } sim_state_e;

endpackage

// File: rtl/orpsoc_sim_rst_seq.sv
// orpsoc_sim_rst_seq: staggered reset release sequencer.
// Counts edges after rst_i falls; domain k is released on edge RST_HOLD + k*RST_STAGGER.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   rst_o         - per-domain active-high resets, bit 0 released first
//   hold_done_o   - high in the cycle whose edge releases domain 0
//   all_rel_o     - high in the cycle whose edge releases the last domain
module orpsoc_sim_rst_seq #(
  parameter int unsigned NUM_RST     = 2,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned RST_STAGGER = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [NUM_RST-1:0] rst_o,
  output logic               hold_done_o,
  output logic               all_rel_o
);

  localparam int unsigned LastRel = RST_HOLD + (NUM_RST - 1) * RST_STAGGER;
  localparam int unsigned CntW    = (LastRel < 1) ? 1 : $clog2(LastRel + 1);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               step;

  // The counter parks at the last release point, so the flags pulse once.
  assign step = (cnt_q != CntW'(LastRel));

  always_comb begin
    cnt_d = cnt_q;
    rst_d = rst_q;
    if (step) begin
      cnt_d = cnt_q + 1'b1;
      for (int unsigned k = 0; k < NUM_RST; k++) begin
        if (cnt_d == CntW'(RST_HOLD + k * RST_STAGGER)) begin
          rst_d[k] = 1'b0;
        end
      end
    end
  end

  assign hold_done_o = step && (cnt_d == CntW'(RST_HOLD));
  assign all_rel_o   = step && (cnt_d == CntW'(LastRel));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rst_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      rst_q <= rst_d;
    end
  end

  assign rst_o = rst_q;

endmodule

// File: rtl/orpsoc_sim_ctrl.sv
// orpsoc_sim_ctrl: simulation supervisor - reset sequencing, run-cycle timeout and
// l.nop exit / report / putc detection on the CPU writeback instruction stream.
// Optional console decode (putc / report pulses) is built when SIM_CTRL_CONSOLE_EN
// is defined; otherwise those outputs are tied to 0.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   timeout_i                - run-cycle limit, 0 disables
//   wb_insn_i/_vld_i, gpr3_i - retiring instruction and current r3
//   rst_o, running_o         - domain resets, test running
//   done_o, pass_o, timeout_o, exit_code_o, cycle_cnt_o - end-of-test status
//   putc_*, report_*         - console pulses and data
module orpsoc_sim_ctrl
  import orpsoc_sim_pkg::*;
#(
  parameter int unsigned NUM_RST     = 2,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned RST_STAGGER = 4,
  parameter int unsigned TIMEOUT_W   = 32,
  parameter logic [31:0] NOP_EXIT    = NOP_EXIT_DEF,
  parameter logic [31:0] NOP_REPORT  = NOP_REPORT_DEF,
  parameter logic [31:0] NOP_PUTC    = NOP_PUTC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic [31:0]          wb_insn_i,
  input  logic                 wb_insn_vld_i,
  input  logic [31:0]          gpr3_i,
  output logic [NUM_RST-1:0]   rst_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [31:0]          exit_code_o,
  output logic [TIMEOUT_W-1:0] cycle_cnt_o,
  output logic                 putc_vld_o,
  output logic [7:0]           putc_char_o,
  output logic                 report_vld_o,
  output logic [31:0]          report_data_o
);

  sim_state_e           state_q, state_d;
  logic                 hold_done, all_rel;
  logic                 in_run, exit_hit, to_hit;
  logic                 done_q, done_d, pass_q, pass_d, to_q, to_d;
  logic [31:0]          code_q, code_d;
  logic [TIMEOUT_W-1:0] cyc_q, cyc_d;

  orpsoc_sim_rst_seq #(
    .NUM_RST     (NUM_RST),
    .RST_HOLD    (RST_HOLD),
    .RST_STAGGER (RST_STAGGER)
  ) u_rst_seq (
    .clk_i       (clk),
    .rst_i       (rst),
    .rst_o       (rst_o),
    .hold_done_o (hold_done),
    .all_rel_o   (all_rel)
  );

  assign in_run   = (state_q == StRun);
  assign exit_hit = in_run && wb_insn_vld_i && (wb_insn_i == NOP_EXIT);
  assign to_hit   = in_run && (timeout_i != '0) && (cyc_q == timeout_i - 1'b1);

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    pass_d  = pass_q;
    to_d    = to_q;
    code_d  = code_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      StHold: begin
        // With one domain or no stagger, the last release coincides with the first.
        if (all_rel) begin
          state_d = StRun;
        end else if (hold_done) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (all_rel) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (cyc_q != '1) begin
          cyc_d = cyc_q + 1'b1;
        end
        // Exit takes priority over a simultaneous timeout.
        if (exit_hit) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (gpr3_i == 32'd0);
          code_d  = gpr3_i;
        end else if (to_hit) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          to_d    = 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StHold;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHold;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      code_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      code_q  <= code_d;
      cyc_q   <= cyc_d;
    end
  end

  assign running_o   = in_run;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = to_q;
  assign exit_code_o = code_q;
  assign cycle_cnt_o = cyc_q;

`ifdef SIM_CTRL_CONSOLE_EN
  logic       putc_vld_q, rep_vld_q;
  logic [7:0] putc_char_q;
  logic [31:0] rep_data_q;
  logic       putc_hit, rep_hit;

  assign putc_hit = in_run && wb_insn_vld_i && (wb_insn_i == NOP_PUTC);
  assign rep_hit  = in_run && wb_insn_vld_i && (wb_insn_i == NOP_REPORT);

  // Valid flags pulse for one cycle; data registers hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      putc_vld_q  <= 1'b0;
      putc_char_q <= '0;
      rep_vld_q   <= 1'b0;
      rep_data_q  <= '0;
    end else begin
      putc_vld_q <= putc_hit;
      rep_vld_q  <= rep_hit;
      if (putc_hit) begin
        putc_char_q <= gpr3_i[7:0];
      end
      if (rep_hit) begin
        rep_data_q <= gpr3_i;
      end
    end
  end

  assign putc_vld_o    = putc_vld_q;
  assign putc_char_o   = putc_char_q;
  assign report_vld_o  = rep_vld_q;
  assign report_data_o = rep_data_q;
`else
  logic unused_console;
  assign unused_console = ^{NOP_PUTC, NOP_REPORT};

  assign putc_vld_o    = 1'b0;
  assign putc_char_o   = '0;
  assign report_vld_o  = 1'b0;
  assign report_data_o = '0;
`endif

endmodule

// File: tb/tb_orpsoc_sim_ctrl.sv
// Bench for orpsoc_sim_ctrl: a cycle model pushes expected outputs into a queue as
// each stimulus beat is driven; the entry is popped and compared after the edge.
module tb_orpsoc_sim_ctrl;

  localparam int unsigned NumRst  = 3;
  localparam int unsigned Hold    = 16;
  localparam int unsigned Stag    = 4;
  localparam int unsigned RunEdge = Hold + (NumRst - 1) * Stag;
  localparam logic [31:0] NopExit   = 32'h15000001;
  localparam logic [31:0] NopReport = 32'h15000002;
  localparam logic [31:0] NopPutc   = 32'h15000004;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       timeout_i = '0;
  logic [31:0]       wb_insn_i = '0;
  logic              wb_insn_vld_i = 1'b0;
  logic [31:0]       gpr3_i = '0;
  logic [NumRst-1:0] rst_o;
  logic              running_o, done_o, pass_o, timeout_o;
  logic [31:0]       exit_code_o, cycle_cnt_o;
  logic              putc_vld_o, report_vld_o;
  logic [7:0]        putc_char_o;
  logic [31:0]       report_data_o;

  orpsoc_sim_ctrl #(
    .NUM_RST     (NumRst),
    .RST_HOLD    (Hold),
    .RST_STAGGER (Stag),
    .TIMEOUT_W   (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timeout_i     (timeout_i),
    .wb_insn_i     (wb_insn_i),
    .wb_insn_vld_i (wb_insn_vld_i),
    .gpr3_i        (gpr3_i),
    .rst_o         (rst_o),
    .running_o     (running_o),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .timeout_o     (timeout_o),
    .exit_code_o   (exit_code_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .putc_vld_o    (putc_vld_o),
    .putc_char_o   (putc_char_o),
    .report_vld_o  (report_vld_o),
    .report_data_o (report_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NumRst-1:0] rst_v;
    logic              running;
    logic              done;
    logic              pass;
    logic              to;
    logic [31:0]       code;
    logic [31:0]       cyc;
    logic              putc_v;
    logic [7:0]        putc_c;
    logic              rep_v;
    logic [31:0]       rep_d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: edges since rst fell plus the sticky status.
  int unsigned e;
  logic        m_done, m_pass, m_to;
  logic [31:0] m_code, m_cyc, m_rep_d;
  logic        m_putc_v, m_rep_v;
  logic [7:0]  m_putc_c;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e        = 0;
    m_done   = 1'b0;
    m_pass   = 1'b0;
    m_to     = 1'b0;
    m_code   = '0;
    m_cyc    = '0;
    m_putc_v = 1'b0;
    m_putc_c = '0;
    m_rep_v  = 1'b0;
    m_rep_d  = '0;
  endtask

  task automatic compare_one();
    exp_t x;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
      return;
    end
    x = exp_q.pop_front();
    check_eq("rst_o", 32'(rst_o), 32'(x.rst_v));
    check_eq("running_o", 32'(running_o), 32'(x.running));
    check_eq("done_o", 32'(done_o), 32'(x.done));
    check_eq("pass_o", 32'(pass_o), 32'(x.pass));
    check_eq("timeout_o", 32'(timeout_o), 32'(x.to));
    check_eq("exit_code_o", exit_code_o, x.code);
    check_eq("cycle_cnt_o", cycle_cnt_o, x.cyc);
    check_eq("putc_vld_o", 32'(putc_vld_o), 32'(x.putc_v));
    check_eq("putc_char_o", 32'(putc_char_o), 32'(x.putc_c));
    check_eq("report_vld_o", 32'(report_vld_o), 32'(x.rep_v));
    check_eq("report_data_o", report_data_o, x.rep_d);
  endtask

  // Called at a negedge: drive one beat, predict post-edge outputs, compare after edge.
  task automatic step(input logic vld, input logic [31:0] insn, input logic [31:0] g3,
                      input logic [31:0] to);
    exp_t x;
    logic run_now;
    wb_insn_vld_i = vld;
    wb_insn_i     = insn;
    gpr3_i        = g3;
    timeout_i     = to;
    run_now = !m_done && (e >= RunEdge);
    m_putc_v = 1'b0;
    m_rep_v  = 1'b0;
    if (run_now) begin
      if (vld && insn == NopExit) begin
        m_done = 1'b1;
        m_pass = (g3 == 32'd0);
        m_code = g3;
      end else if (to != 32'd0 && m_cyc == to - 32'd1) begin
        m_done = 1'b1;
        m_pass = 1'b0;
        m_to   = 1'b1;
      end
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
`ifdef SIM_CTRL_CONSOLE_EN
      if (vld && insn == NopPutc) begin
        m_putc_v = 1'b1;
        m_putc_c = g3[7:0];
      end
      if (vld && insn == NopReport) begin
        m_rep_v = 1'b1;
        m_rep_d = g3;
      end
`endif
    end
    e++;
    for (int k = 0; k < int'(NumRst); k++) x.rst_v[k] = (e < Hold + k * Stag);
    x.running = !m_done && (e >= RunEdge);
    x.done    = m_done;
    x.pass    = m_pass;
    x.to      = m_to;
    x.code    = m_code;
    x.cyc     = m_cyc;
    x.putc_v  = m_putc_v;
    x.putc_c  = m_putc_c;
    x.rep_v   = m_rep_v;
    x.rep_d   = m_rep_d;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    compare_one();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [31:0] to);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'h0000_0055, to);
  endtask

  // Raise rst away from any edge and check the asynchronous clear before the next edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    wb_insn_vld_i = 1'b0;
    wb_insn_i     = '0;
    gpr3_i        = '0;
    timeout_i     = '0;
    #1;
    check_eq("rst_rst_o", 32'(rst_o), 32'h7);
    check_eq("rst_running", 32'(running_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_pass", 32'(pass_o), 32'd0);
    check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    check_eq("rst_code", exit_code_o, 32'd0);
    check_eq("rst_cyc", cycle_cnt_o, 32'd0);
    check_eq("rst_putc", {23'd0, putc_vld_o, putc_char_o}, 32'd0);
    check_eq("rst_report", 32'(report_vld_o) | report_data_o, 32'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();

    // Release order, NOP_EXIT during RELEASE ignored, exit pass at run cycle 100.
    apply_reset();
    idle(18, 32'd0);
    step(1'b1, NopExit, 32'd0, 32'd0);
    idle(5, 32'd0);
    check_eq("running_at_24", 32'(running_o), 32'd1);
    check_eq("not_done_after_release_exit", 32'(done_o), 32'd0);
    for (int g = 0; g < 200 && m_cyc != 32'd100; g++) idle(1, 32'd0);
    step(1'b1, NopExit, 32'd0, 32'd0);
    check_eq("pass_exit_cyc", cycle_cnt_o, 32'd101);
    check_eq("pass_exit_pass", 32'(pass_o), 32'd1);
    step(1'b1, NopExit, 32'h0000_0007, 32'd0);
    idle(3, 32'd0);

    // Exit fail with non-zero r3.
    apply_reset();
    idle(30, 32'd0);
    step(1'b1, NopExit, 32'hDEAD_BEEF, 32'd0);
    check_eq("fail_exit_code", exit_code_o, 32'hDEAD_BEEF);
    idle(2, 32'd0);

    // Timeout after 50 run cycles; a later exit changes nothing.
    apply_reset();
    for (int g = 0; g < 200 && !m_done; g++) idle(1, 32'd50);
    check_eq("timeout_cyc", cycle_cnt_o, 32'd50);
    check_eq("timeout_flag", 32'(timeout_o), 32'd1);
    step(1'b1, NopExit, 32'd0, 32'd50);
    idle(2, 32'd50);

    // Timeout lowered mid-run, then exit and timeout on the same beat.
    apply_reset();
    idle(30, 32'd1000);
    for (int g = 0; g < 200 && m_cyc != 32'd29; g++) idle(1, 32'd30);
    step(1'b1, NopExit, 32'd0, 32'd30);
    check_eq("tie_timeout", 32'(timeout_o), 32'd0);
    check_eq("tie_pass", 32'(pass_o), 32'd1);
    idle(2, 32'd30);

    // Console decode, then rst asserted mid-run.
    apply_reset();
    idle(28, 32'd0);
    step(1'b1, NopPutc, 32'h0000_0041, 32'd0);
    idle(1, 32'd0);
    step(1'b1, NopReport, 32'h1234_5678, 32'd0);
    idle(2, 32'd0);
    apply_reset();
    idle(3, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
